c4_seq_ctrl: RTL and testbench

- Sequencer/checker for the c4 two-bit state machine (state outputs s, t; serial input a).
- On start, resets the controlled FSM, drives a programmed bit pattern onto a (one bit per clock), and compares each resulting {s,t} against a programmed expected state.
- Reports mismatch count, index of the first failing step, and pass/fail.
- Sits beside c4 in lab/self-test builds and replaces hand-written stimulus sequences.

---
 rtl/c4_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_c4_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/c4_seq_ctrl.sv
// c4_seq_ctrl -- sequencer/checker for the c4 two-bit state machine.
//
// On an accepted start the controller pulses c4's reset for one cycle,
// shifts a programmed pattern onto a (one bit per clock), and compares each
// resulting {s,t} against a programmed expected state. It reports the
// mismatch count, the index of the first failing step and pass/fail.
// All registers update on the falling edge of n_clk_i, the same edge as c4.
//
// Optional build macro: C4_SEQ_STOP_EN -- abort the run on the first
// mismatch and go straight to FINISH.
//
// Ports:
//   n_clk_i      clock (falling edge active)
//   rst_i        asynchronous active-high reset
//   start_i      run request, sampled only in IDLE
//   len_i        number of steps (clamped to MAX_LEN), captured at start
//   pattern_i    bit k driven onto a_o at step k, captured at start
//   exp_st_i     bits [2k+1:2k] = expected {s,t} after step k
//   s_i, t_i     state bits from c4
//   a_o          serial input to c4
//   fsm_rst_n_o  active-low reset to c4
//   busy_o       high from the cycle after start acceptance until done
//   done_o       one-cycle end-of-run pulse
//   err_cnt_o    saturating mismatch count
//   first_err_o  step index of the first mismatch (0 if none)
//   pass_o       last run finished with zero mismatches
module c4_seq_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CW      = 4
) (
  input  logic                 n_clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CW-1:0]        len_i,
  input  logic [MAX_LEN-1:0]   pattern_i,
  input  logic [2*MAX_LEN-1:0] exp_st_i,
  input  logic                 s_i,
  input  logic                 t_i,
  output logic                 a_o,
  output logic                 fsm_rst_n_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CW-1:0]        err_cnt_o,
  output logic [CW-1:0]        first_err_o,
  output logic                 pass_o
);

  typedef enum logic [2:0] {IDLE, RESET, RUN, CHECK, FINISH} state_t;

  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);

  state_t               state_q, state_d;
  logic [CW-1:0]        len_q, len_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [2*MAX_LEN-1:0] exp_q, exp_d;
  logic [CW-1:0]        k_q, k_d;
  logic [CW-1:0]        err_q, err_d;
  logic [CW-1:0]        first_q, first_d;
  logic                 pass_q, pass_d;
  logic                 a_q, a_d;
  logic                 frst_n_q, frst_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // c4 consumes a for step k at the end of RUN k, so during RUN k+1 (or
  // CHECK after the last step) {s,t} reflects step k. The step being
  // checked in the current cycle is therefore always k_q-1.
  logic [CW-1:0] k_m1;
  logic [1:0]    exp_cur;
  logic          cmp_en;
  logic          mis;

  assign k_m1   = k_q - CW'(1);
  assign cmp_en = ((state_q == RUN) && (k_q != '0)) || (state_q == CHECK);

  always_comb begin
    exp_cur = 2'b00;
    for (int i = 0; i < MAX_LEN; i++)
      if (k_m1 == CW'(i)) exp_cur = exp_q[2*i +: 2];
  end

  assign mis = cmp_en && ({s_i, t_i} != exp_cur);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pat_d    = pat_q;
    exp_d    = exp_q;
    k_d      = k_q;
    err_d    = err_q;
    first_d  = first_q;
    pass_d   = pass_q;
    a_d      = 1'b0;
    frst_n_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (mis) begin
      if (err_q != '1) err_d = err_q + CW'(1);
      if (err_q == '0) first_d = k_m1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = (len_i > MAX_LEN_C) ? MAX_LEN_C : len_i;
          pat_d   = pattern_i;
          exp_d   = exp_st_i;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          k_d     = '0;
          state_d = RESET;
        end
      end
      RESET: begin
        k_d     = '0;
        state_d = (len_q == '0) ? FINISH : RUN;
      end
      RUN: begin
        k_d = k_q + CW'(1);
        if ((k_q + CW'(1)) == len_q) state_d = CHECK;
      end
      CHECK:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef C4_SEQ_STOP_EN
    if (mis) state_d = FINISH;
`endif

    // Outputs are registered: derive them from the next state so they
    // line up with the state they belong to.
    if (state_d == FINISH) pass_d = (err_d == '0);
    if (state_d == RUN) begin
      for (int i = 0; i < MAX_LEN; i++)
        if (k_d == CW'(i)) a_d = pat_d[i];
    end
    frst_n_d = (state_d != RESET);
    busy_d   = (state_d == RESET) || (state_d == RUN) || (state_d == CHECK);
    done_d   = (state_d == FINISH);
  end

  always_ff @(negedge n_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      k_q      <= '0;
      err_q    <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
      a_q      <= 1'b0;
      frst_n_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      exp_q    <= exp_d;
      k_q      <= k_d;
      err_q    <= err_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
      a_q      <= a_d;
      frst_n_q <= frst_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign a_o         = a_q;
  assign fsm_rst_n_o = frst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_cnt_o   = err_q;
  assign first_err_o = first_q;
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_c4_seq_ctrl.sv
// Bench for c4_seq_ctrl: directed vector table plus hand-written sequences
// for reset-mid-run, ignored starts and back-to-back runs. A small c4
// stand-in returns a scripted {s,t} for each step.
module tb_c4_seq_ctrl;

  logic        n_clk, rst, start;
  logic [3:0]  len;
  logic [7:0]  pattern;
  logic [15:0] exp_st;
  logic        s, t;
  logic        a, fsm_rst_n, busy, done, pass;
  logic [3:0]  err_cnt, first_err;

  int checks = 0;
  int failures = 0;

  c4_seq_ctrl #(.MAX_LEN(8), .CW(4)) dut (
    .n_clk_i(n_clk), .rst_i(rst), .start_i(start), .len_i(len),
    .pattern_i(pattern), .exp_st_i(exp_st), .s_i(s), .t_i(t),
    .a_o(a), .fsm_rst_n_o(fsm_rst_n), .busy_o(busy), .done_o(done),
    .err_cnt_o(err_cnt), .first_err_o(first_err), .pass_o(pass)
  );

  initial n_clk = 1'b1;
  always #5 n_clk = ~n_clk;

`ifdef C4_SEQ_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // c4 stand-in: counts busy cycles after its reset; after the edge ending
  // step j it presents resp[2j+1:2j] on {s,t}. Also logs a per step.
  logic [15:0] resp;
  logic [15:0] a_log;
  int          j, pj;
  bit          pend;

  always @(posedge n_clk) begin
    if (!fsm_rst_n) begin
      j = 0; pend = 0; a_log = '0;
    end else if (busy) begin
      a_log = a_log | (16'(a) << j);
      pj = j; pend = 1; j++;
    end else begin
      pend = 0;
    end
  end

  always @(negedge n_clk) begin
    logic [15:0] tmp;
    #1;
    if (pend) begin
      tmp = resp >> (2*pj);
      {s, t} = tmp[1:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  typedef struct {
    logic [3:0]  len;
    logic [7:0]  pat;
    logic [15:0] exp;
    logic [15:0] resp;
    int          err;
    int          first;
    bit          pass;
    int          edges;
    int          edges_stop;
  } vec_t;

  // Applies one run and checks latency, busy length, c4 reset length,
  // results, the driven pattern and result holding after done.
  task automatic run_vec(input vec_t v, input string tag);
    int n, bc, rl, L, e_edges, e_err;
    bit got;
    logic [15:0] mask_a, mask_p;
    @(posedge n_clk);
    len = v.len; pattern = v.pat; exp_st = v.exp; resp = v.resp; start = 1'b1;
    @(posedge n_clk);
    start = 1'b0;
    n = 0; bc = 0; rl = 0; got = 0;
    while (n < 40) begin
      if (done) begin got = 1; break; end
      bc += int'(busy);
      rl += int'(!fsm_rst_n);
      @(posedge n_clk);
      n++;
    end
    chk({tag, ".done_seen"}, 32'(got), 1);
    L = (v.len > 8) ? 8 : int'(v.len);
    e_edges = (STOP && v.err > 0) ? v.edges_stop : v.edges;
    e_err   = (STOP && v.err > 0) ? 1 : v.err;
    chk({tag, ".done_edge"}, n, e_edges);
    chk({tag, ".busy_cycles"}, bc, e_edges);
    chk({tag, ".c4_rst_cycles"}, rl, 1);
    chk({tag, ".err_cnt"}, 32'(err_cnt), e_err);
    chk({tag, ".first_err"}, 32'(first_err), v.first);
    chk({tag, ".pass"}, 32'(pass), 32'(v.pass));
    if (!(STOP && v.err > 0)) begin
      mask_a = 16'((32'd1 << (L + 1)) - 1);
      mask_p = 16'((32'd1 << L) - 1);
      chk({tag, ".steps"}, j, (L == 0) ? 0 : L + 1);
      chk({tag, ".a_seq"}, 32'(a_log & mask_a), 32'({8'h00, v.pat} & mask_p));
    end
    @(posedge n_clk);
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".err_hold"}, 32'(err_cnt), e_err);
    chk({tag, ".pass_hold"}, 32'(pass), 32'(v.pass));
  endtask

  vec_t vecs[7];

  initial begin
    int n, bc, d1, d2, rl;
    bit seen;

    //            len    pat      exp       resp     err first pass edges stop
    vecs[0] = '{4'd1,  8'h00, 16'hFFFC, 16'h0000, 0, 0, 1, 3,  3};
    vecs[1] = '{4'd1,  8'h01, 16'h0001, 16'h0001, 0, 0, 1, 3,  3};
    vecs[2] = '{4'd4,  8'h0B, 16'h0055, 16'h0045, 1, 2, 0, 6,  5};
    vecs[3] = '{4'd0,  8'hFF, 16'hFFFF, 16'h0000, 0, 0, 1, 1,  1};
    vecs[4] = '{4'd15, 8'hA5, 16'h1B2D, 16'h1B2D, 0, 0, 1, 10, 10};
    vecs[5] = '{4'd8,  8'hFF, 16'h0000, 16'hFFF0, 6, 2, 0, 10, 5};
    vecs[6] = '{4'd3,  8'h06, 16'h003F, 16'h0000, 3, 0, 0, 5,  3};

    rst = 1'b1; start = 1'b0; len = '0; pattern = '0; exp_st = '0;
    resp = '0; s = 1'b0; t = 1'b0;
    repeat (2) @(posedge n_clk);
    chk("rst.a", 32'(a), 0);
    chk("rst.fsm_rst_n", 32'(fsm_rst_n), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err_cnt", 32'(err_cnt), 0);
    chk("rst.first_err", 32'(first_err), 0);
    chk("rst.pass", 32'(pass), 0);
    rst = 1'b0;
    @(posedge n_clk);
    chk("idle.fsm_rst_n", 32'(fsm_rst_n), 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in RUN step 2: outputs drop at once, no done afterwards.
    @(posedge n_clk);
    len = 4'd4; pattern = 8'h04; exp_st = 16'h0055; resp = 16'h0000; start = 1'b1;
    @(posedge n_clk);
    start = 1'b0;
    repeat (3) @(posedge n_clk);
    chk("midrst.pre_a", 32'(a), 1);
    chk("midrst.pre_err", 32'(err_cnt), 1);
    rst = 1'b1;
    #1;
    chk("midrst.a", 32'(a), 0);
    chk("midrst.fsm_rst_n", 32'(fsm_rst_n), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.err_cnt", 32'(err_cnt), 0);
    chk("midrst.first_err", 32'(first_err), 0);
    chk("midrst.pass", 32'(pass), 0);
    @(posedge n_clk);
    rst = 1'b0;
    seen = 0; bc = 0;
    repeat (8) begin
      @(posedge n_clk);
      seen |= done;
      bc += int'(busy);
    end
    chk("midrst.no_done", 32'(seen), 0);
    chk("midrst.no_busy", bc, 0);
    chk("midrst.idle", 32'(fsm_rst_n), 1);

    // start pulsed mid-run and during FINISH are both ignored.
    @(posedge n_clk);
    len = 4'd4; pattern = 8'h05; exp_st = 16'h0000; resp = 16'h0000; start = 1'b1;
    @(posedge n_clk);
    start = 1'b0;
    n = 0; seen = 0;
    while (n < 40) begin
      if (done) begin seen = 1; break; end
      if (n == 2) begin start = 1'b1; len = 4'd1; end
      if (n == 3) start = 1'b0;
      @(posedge n_clk);
      n++;
    end
    chk("ignore.done_seen", 32'(seen), 1);
    chk("ignore.done_edge", n, 6);
    start = 1'b1;
    @(posedge n_clk);
    start = 1'b0;
    bc = 0;
    repeat (6) begin
      bc += int'(busy);
      @(posedge n_clk);
    end
    chk("ignore.finish_start", bc, 0);

    // start held high: back-to-back runs, each with its own c4 reset.
    len = 4'd2; pattern = 8'h03; exp_st = 16'h0000; resp = 16'h0000; start = 1'b1;
    d1 = -1; d2 = -1; rl = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge n_clk);
      if (done && d1 < 0) d1 = c;
      else if (done && d2 < 0) d2 = c;
      if (d1 >= 0 && d2 < 0 && !fsm_rst_n) rl++;
    end
    start = 1'b0;
    chk("held.first_done", 32'(d1 >= 0), 1);
    chk("held.period", d2 - d1, 6);
    chk("held.c4_rst_between", rl, 1);
    repeat (10) @(posedge n_clk);
    chk("held.pass", 32'(pass), 1);
    chk("held.idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
